// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
//   Bundle between decode/forwarding and the EX operand register stage.
//   Parameter: DBITS - operand/result data width.
//   Decode side : id_valid, id_op, id_reg1, id_reg2, id_uses_reg2,
//                 id_use_imm, id_imm, id_dest, rf_data1, rf_data2
//   Forwarding  : fwd_sel1, fwd_sel2, alu_result, mem_result, wb_result
//   Control     : flush, mem_stall, stall_out (back to decode)
//   EX side     : ex_valid, ex_op, ex_dest, ex_opA, ex_opB, ex_store_data
//   Optional    : bubble_cnt, present only when EX_BUBBLE_CNT_EN is defined.
//   Modports: master (decode/forwarding driver), slave (the EX stage).
interface ex_operand_stage_if #(
   parameter int unsigned DBITS = 32
);
   logic             id_valid;
   logic [3:0]       id_op;
   logic [3:0]       id_reg1;
   logic [3:0]       id_reg2;
   logic             id_uses_reg2;
   logic             id_use_imm;
   logic [DBITS-1:0] id_imm;
   logic [3:0]       id_dest;
   logic [DBITS-1:0] rf_data1;
   logic [DBITS-1:0] rf_data2;
   logic [1:0]       fwd_sel1;
   logic [1:0]       fwd_sel2;
   logic [DBITS-1:0] alu_result;
   logic [DBITS-1:0] mem_result;
   logic [DBITS-1:0] wb_result;
   logic             flush;
   logic             mem_stall;
   logic             stall_out;
   logic             ex_valid;
   logic [3:0]       ex_op;
   logic [3:0]       ex_dest;
   logic [DBITS-1:0] ex_opA;
   logic [DBITS-1:0] ex_opB;
   logic [DBITS-1:0] ex_store_data;
`ifdef EX_BUBBLE_CNT_EN
   logic [15:0]      bubble_cnt;
`endif

   modport master (
      output id_valid, id_op, id_reg1, id_reg2, id_uses_reg2, id_use_imm,
             id_imm, id_dest, rf_data1, rf_data2, fwd_sel1, fwd_sel2,
             alu_result, mem_result, wb_result, flush, mem_stall,
`ifdef EX_BUBBLE_CNT_EN
      input  bubble_cnt,
`endif
      input  stall_out, ex_valid, ex_op, ex_dest, ex_opA, ex_opB,
             ex_store_data
   );

   modport slave (
      input  id_valid, id_op, id_reg1, id_reg2, id_uses_reg2, id_use_imm,
             id_imm, id_dest, rf_data1, rf_data2, fwd_sel1, fwd_sel2,
             alu_result, mem_result, wb_result, flush, mem_stall,
`ifdef EX_BUBBLE_CNT_EN
      output bubble_cnt,
`endif
      output stall_out, ex_valid, ex_op, ex_dest, ex_opA, ex_opB,
             ex_store_data
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   Decode-to-execute pipeline register. Selects operands through the
//   forwarding muxes, registers them into EX, inserts a one-cycle bubble on
//   a load-use hazard (raising stall_out to decode), and honours branch
//   flush and the global memory-stall freeze.
//   Ports:
//     clk     - rising-edge clock
//     reset_n - asynchronous active-low reset
//     bus     - ex_operand_stage_if.slave (decode, forwarding, control, EX)
//   Parameters: DBITS, OP_NOP (bubble opcode), OP_SW (store), OP_LW (load).
//   Optional: define EX_BUBBLE_CNT_EN to add bus.bubble_cnt, a saturating
//   count of load-use bubbles.
module ex_operand_stage #(
   parameter int unsigned DBITS  = 32,
   parameter logic [3:0]  OP_NOP = 4'b0000,
   parameter logic [3:0]  OP_SW  = 4'b0011,
   parameter logic [3:0]  OP_LW  = 4'b0100
) (
   input logic               clk,
   input logic               reset_n,
   ex_operand_stage_if.slave bus
);

   // Store data always travels on the reg2 path, so OP_SW needs no datapath
   // decode here; it only has to stay distinct from the load and bubble codes.
   if (OP_SW == OP_LW || OP_SW == OP_NOP || OP_LW == OP_NOP) begin : g_op_clash
      $error("ex_operand_stage: OP_NOP, OP_SW and OP_LW must be distinct");
   end

   logic             ex_valid_q;
   logic [3:0]       ex_op_q;
   logic [3:0]       ex_dest_q;
   logic [DBITS-1:0] ex_opa_q;
   logic [DBITS-1:0] ex_opb_q;
   logic [DBITS-1:0] ex_sd_q;

   logic [DBITS-1:0] mux1;
   logic [DBITS-1:0] mux2;
   logic [DBITS-1:0] opa;
   logic [DBITS-1:0] opb;
   logic             lu_hazard;

   always_comb begin
      mux1 = bus.rf_data1;
      unique case (bus.fwd_sel1)
         2'b00: mux1 = bus.rf_data1;
         2'b01: mux1 = bus.alu_result;
         2'b10: mux1 = bus.mem_result;
         2'b11: mux1 = bus.wb_result;
      endcase
   end

   always_comb begin
      mux2 = bus.rf_data2;
      unique case (bus.fwd_sel2)
         2'b00: mux2 = bus.rf_data2;
         2'b01: mux2 = bus.alu_result;
         2'b10: mux2 = bus.mem_result;
         2'b11: mux2 = bus.wb_result;
      endcase
   end

   assign opa = mux1;
   assign opb = bus.id_use_imm ? bus.id_imm : mux2;

   // Register 0 is an ordinary index here; no zero-register exemption.
   assign lu_hazard = ex_valid_q && (ex_op_q == OP_LW) && bus.id_valid &&
                      ((ex_dest_q == bus.id_reg1) ||
                       (bus.id_uses_reg2 && (ex_dest_q == bus.id_reg2)));

   assign bus.stall_out = (lu_hazard || bus.mem_stall) && !bus.flush;

   // Priority: flush > mem_stall hold > load-use bubble > capture > bubble.
   // The bubble clears ex_op, so a load-use stall lasts exactly one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= OP_NOP;
         ex_dest_q  <= '0;
         ex_opa_q   <= '0;
         ex_opb_q   <= '0;
         ex_sd_q    <= '0;
      end else if (bus.flush) begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= OP_NOP;
         ex_dest_q  <= '0;
         ex_opa_q   <= '0;
         ex_opb_q   <= '0;
         ex_sd_q    <= '0;
      end else if (bus.mem_stall) begin
         ex_valid_q <= ex_valid_q;
      end else if (!lu_hazard && bus.id_valid) begin
         ex_valid_q <= 1'b1;
         ex_op_q    <= bus.id_op;
         ex_dest_q  <= bus.id_dest;
         ex_opa_q   <= opa;
         ex_opb_q   <= opb;
         ex_sd_q    <= mux2;
      end else begin
         ex_valid_q <= 1'b0;
         ex_op_q    <= OP_NOP;
         ex_dest_q  <= '0;
         ex_opa_q   <= '0;
         ex_opb_q   <= '0;
         ex_sd_q    <= '0;
      end
   end

   assign bus.ex_valid      = ex_valid_q;
   assign bus.ex_op         = ex_op_q;
   assign bus.ex_dest       = ex_dest_q;
   assign bus.ex_opA        = ex_opa_q;
   assign bus.ex_opB        = ex_opb_q;
   assign bus.ex_store_data = ex_sd_q;

`ifdef EX_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_q;

   // Counts only load-use bubbles, i.e. edges not pre-empted by flush/freeze.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bubble_cnt_q <= '0;
      end else if (!bus.flush && !bus.mem_stall && lu_hazard &&
                   (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
   end

   assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
//   Directed bench for ex_operand_stage. Each step drives decode/forwarding
//   inputs, checks stall_out combinationally, pushes the expected EX state
//   into a scoreboard queue, and pops/compares it after the next rising edge.
//   Define EX_BUBBLE_CNT_EN to also check bubble_cnt.
module tb_ex_operand_stage;

   typedef struct packed {
      logic        valid;
      logic [3:0]  op;
      logic [3:0]  dest;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
   } exp_t;

   logic clk;
   logic reset_n;
   int   npass;
   int   ntotal;
   exp_t sb[$];

   ex_operand_stage_if #(.DBITS(32)) bus ();

   ex_operand_stage #(
      .DBITS (32),
      .OP_NOP(4'b0000),
      .OP_SW (4'b0011),
      .OP_LW (4'b0100)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t bub();
      return '{valid: 1'b0, op: 4'h0, dest: 4'h0, a: 32'h0, b: 32'h0, sd: 32'h0};
   endfunction

   function automatic exp_t cap(input logic [3:0] op, input logic [3:0] dest,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sd);
      return '{valid: 1'b1, op: op, dest: dest, a: a, b: b, sd: sd};
   endfunction

   task automatic chk(input string tag, input string name,
                      input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s.%s: observed %h expected %h", tag, name, obs, exp);
   endtask

   task automatic chk_ex(input string tag, input exp_t e);
      chk(tag, "ex_valid", {31'b0, bus.ex_valid}, {31'b0, e.valid});
      chk(tag, "ex_op", {28'b0, bus.ex_op}, {28'b0, e.op});
      chk(tag, "ex_dest", {28'b0, bus.ex_dest}, {28'b0, e.dest});
      chk(tag, "ex_opA", bus.ex_opA, e.a);
      chk(tag, "ex_opB", bus.ex_opB, e.b);
      chk(tag, "ex_store_data", bus.ex_store_data, e.sd);
   endtask

   task automatic set_id(input logic v, input logic [3:0] op,
                         input logic [3:0] r1, input logic [3:0] r2,
                         input logic uses2, input logic useimm,
                         input logic [31:0] imm, input logic [3:0] dest);
      bus.id_valid     = v;
      bus.id_op        = op;
      bus.id_reg1      = r1;
      bus.id_reg2      = r2;
      bus.id_uses_reg2 = uses2;
      bus.id_use_imm   = useimm;
      bus.id_imm       = imm;
      bus.id_dest      = dest;
   endtask

   task automatic set_fwd(input logic [1:0] s1, input logic [1:0] s2,
                          input logic [31:0] rf1, input logic [31:0] rf2);
      bus.fwd_sel1 = s1;
      bus.fwd_sel2 = s2;
      bus.rf_data1 = rf1;
      bus.rf_data2 = rf2;
   endtask

   // Called 1 time unit after a rising edge with inputs already driven.
   task automatic step(input string tag, input logic exp_stall, input exp_t e);
      exp_t got;
      #1;
      chk(tag, "stall_out", {31'b0, bus.stall_out}, {31'b0, exp_stall});
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         $display("FAIL %s.scoreboard: observed empty expected entry", tag);
      end else begin
         got = sb.pop_front();
         chk_ex(tag, got);
      end
   endtask

   initial begin
      npass   = 0;
      ntotal  = 0;
      reset_n = 1'b0;
      set_id(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
      set_fwd(2'b00, 2'b00, 32'h0, 32'h0);
      bus.alu_result = 32'h0;
      bus.mem_result = 32'h0;
      bus.wb_result  = 32'h0;
      bus.flush      = 1'b0;
      bus.mem_stall  = 1'b0;

      #3;
      chk_ex("reset", bub());
      chk("reset", "stall_out", {31'b0, bus.stall_out}, 32'h0);
`ifdef EX_BUBBLE_CNT_EN
      chk("reset", "bubble_cnt", {16'b0, bus.bubble_cnt}, 32'h0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Forwarding from ALU (reg1) and WB (reg2)
      set_id(1'b1, 4'h1, 4'h1, 4'h2, 1'b1, 1'b0, 32'h0, 4'h3);
      set_fwd(2'b01, 2'b11, 32'h0, 32'h0);
      bus.alu_result = 32'h1234;
      bus.wb_result  = 32'hBEEF;
      step("fwd", 1'b0, cap(4'h1, 4'h3, 32'h1234, 32'hBEEF, 32'hBEEF));

      // Load into EX, dest 5
      set_id(1'b1, 4'h4, 4'h1, 4'h2, 1'b0, 1'b1, 32'h4, 4'h5);
      set_fwd(2'b00, 2'b00, 32'h100, 32'h200);
      step("lw1", 1'b0, cap(4'h4, 4'h5, 32'h100, 32'h4, 32'h200));

      // Dependent on reg 5: one bubble, then capture with MEM forwarding
      set_id(1'b1, 4'h1, 4'h5, 4'h7, 1'b1, 1'b0, 32'h0, 4'h6);
      step("lu_stall", 1'b1, bub());
      set_fwd(2'b10, 2'b00, 32'h100, 32'h22);
      bus.mem_result = 32'hA5A5;
      step("lu_resume", 1'b0, cap(4'h1, 4'h6, 32'hA5A5, 32'h22, 32'h22));

      // Back-to-back dependent loads
      set_id(1'b1, 4'h4, 4'h6, 4'h0, 1'b0, 1'b1, 32'h0, 4'h5);
      set_fwd(2'b00, 2'b00, 32'h10, 32'h20);
      step("b2b_lw_a", 1'b0, cap(4'h4, 4'h5, 32'h10, 32'h0, 32'h20));
      set_id(1'b1, 4'h4, 4'h5, 4'h0, 1'b0, 1'b1, 32'h0, 4'h7);
      step("b2b_stall", 1'b1, bub());
      step("b2b_lw_b", 1'b0, cap(4'h4, 4'h7, 32'h10, 32'h0, 32'h20));
`ifdef EX_BUBBLE_CNT_EN
      chk("b2b", "bubble_cnt", {16'b0, bus.bubble_cnt}, 32'd2);
`endif

      // Flush beats load-use hazard and mem_stall
      set_id(1'b1, 4'h1, 4'h7, 4'h0, 1'b0, 1'b0, 32'h0, 4'h8);
      bus.mem_stall = 1'b1;
      bus.flush     = 1'b1;
      step("flush", 1'b0, bub());
      bus.flush     = 1'b0;
      bus.mem_stall = 1'b0;

      // Freeze: load op=1/opA=7, then hold for three cycles
      set_id(1'b1, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 32'h9, 4'h0);
      set_fwd(2'b00, 2'b00, 32'h7, 32'h3);
      step("pre_freeze", 1'b0, cap(4'h1, 4'h0, 32'h7, 32'h9, 32'h3));
      bus.mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 4'(i + 2), 4'h1, 4'h2, 1'b1, 1'b0, 32'(i), 4'(i + 10));
         set_fwd(2'b00, 2'b01, 32'(100 + i), 32'(200 + i));
         bus.alu_result = 32'(300 + i);
         step($sformatf("freeze%0d", i), 1'b1, cap(4'h1, 4'h0, 32'h7, 32'h9, 32'h3));
      end
      bus.mem_stall = 1'b0;

      // Store: immediate on B, forwarded reg2 on store data
      set_id(1'b1, 4'h3, 4'h2, 4'h0, 1'b1, 1'b1, 32'h8, 4'h0);
      set_fwd(2'b00, 2'b10, 32'h1, 32'h3);
      bus.mem_result = 32'h55;
      step("store", 1'b0, cap(4'h3, 4'h0, 32'h1, 32'h8, 32'h55));

      // Register 0 is not special: load to r0 then hazard through reg2
      set_id(1'b1, 4'h4, 4'h1, 4'h0, 1'b0, 1'b1, 32'h0, 4'h0);
      set_fwd(2'b00, 2'b00, 32'h1, 32'h3);
      step("lw_r0", 1'b0, cap(4'h4, 4'h0, 32'h1, 32'h0, 32'h3));
      set_id(1'b1, 4'h1, 4'h3, 4'h0, 1'b1, 1'b0, 32'h0, 4'h4);
      step("r0_stall", 1'b1, bub());

      // Invalid decode: bubble, and a matching invalid decode raises no stall
      set_id(1'b0, 4'h1, 4'h3, 4'h0, 1'b1, 1'b0, 32'h0, 4'h4);
      step("idle", 1'b0, bub());
      set_id(1'b1, 4'h4, 4'h1, 4'h0, 1'b0, 1'b1, 32'h0, 4'h2);
      step("lw_r2", 1'b0, cap(4'h4, 4'h2, 32'h1, 32'h0, 32'h3));
      set_id(1'b0, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 32'h0, 4'h1);
      step("invalid_match", 1'b0, bub());

      // reg2 ignored when not used
      set_id(1'b1, 4'h4, 4'h1, 4'h0, 1'b0, 1'b1, 32'h0, 4'h9);
      step("lw_r9", 1'b0, cap(4'h4, 4'h9, 32'h1, 32'h0, 32'h3));
      set_id(1'b1, 4'h1, 4'h1, 4'h9, 1'b0, 1'b0, 32'h0, 4'h1);
      step("no_reg2", 1'b0, cap(4'h1, 4'h1, 32'h1, 32'h3, 32'h3));
`ifdef EX_BUBBLE_CNT_EN
      chk("cnt", "bubble_cnt", {16'b0, bus.bubble_cnt}, 32'd3);
`endif

      // Reset mid-stall with EX valid
      set_id(1'b1, 4'h4, 4'h1, 4'h0, 1'b0, 1'b1, 32'h0, 4'h9);
      step("lw_pre_rst", 1'b0, cap(4'h4, 4'h9, 32'h1, 32'h0, 32'h3));
      set_id(1'b1, 4'h1, 4'h9, 4'h0, 1'b0, 1'b0, 32'h0, 4'h1);
      #1;
      chk("pre_rst", "stall_out", {31'b0, bus.stall_out}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk_ex("mid_rst", bub());
      chk("mid_rst", "stall_out", {31'b0, bus.stall_out}, 32'h0);
`ifdef EX_BUBBLE_CNT_EN
      chk("mid_rst", "bubble_cnt", {16'b0, bus.bubble_cnt}, 32'h0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Decode-to-execute pipeline register, directly downstream of the forwarding unit.
- Consumes the forwarding unit's reg1/reg2 mux selects and the ALU/MEM/WB result buses to pick operands, then registers them into EX.
- Detects load-use hazards, inserts one-cycle bubbles and raises a stall to decode.
- Honours a branch flush and a global memory-stall freeze.

Parameters:
- DBITS, 32: operand/result data width.
- OP_NOP, 4'b0000: opcode used for bubbles.
- OP_SW, 4'b0011: store opcode; store data is taken from the reg2 path.
- OP_LW, 4'b0100: load opcode; triggers the load-use check.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_op  in  4  decoded opcode.
- id_reg1, id_reg2  in  4 each  source register indices.
- id_uses_reg2  in  1  instruction reads reg2; id_reg1 is always read.
- id_use_imm  in  1  operand B takes the immediate.
- id_imm  in  DBITS  sign-extended immediate.
- id_dest  in  4  destination index.
- rf_data1, rf_data2  in  DBITS  register-file read data.
- fwd_sel1, fwd_sel2  in  2 each  forwarding selects from the forwarding unit: 00 REG, 01 ALU, 10 MEM, 11 WB.
- alu_result, mem_result, wb_result  in  DBITS each  forwarding sources.
- flush  in  1  branch flush, kills the decode instruction.
- mem_stall  in  1  freeze the pipeline.
- stall_out  out  1  decode must hold its instruction.
- ex_valid  out  1  registered valid.
- ex_op  out  4  registered opcode.
- ex_dest  out  4  registered destination.
- ex_opA, ex_opB, ex_store_data  out  DBITS each  registered operands.

Behaviour:
- Reset (async, reset_n=0): ex_valid=0, ex_op=OP_NOP, ex_dest=0, ex_opA/ex_opB/ex_store_data=0, stall_out=0. Reset mid-stall drops the bubble/stall state immediately.
- Operand mux (combinational, per source):
  - fwd_selN 00 -> rf_dataN; 01 -> alu_result; 10 -> mem_result; 11 -> wb_result.
  - opA = mux1.
  - opB = id_use_imm ? id_imm : mux2.
  - store_data = mux2, always the forwarded reg2 value.
- Hazard: lu_hazard = ex_valid && ex_op==OP_LW && id_valid && (ex_dest==id_reg1 || (id_uses_reg2 && ex_dest==id_reg2)).
- stall_out = (lu_hazard || mem_stall) && !flush. Combinational, no added latency.
- Per rising edge, priority order:
  1. flush=1: load bubble (ex_valid=0, ex_op=OP_NOP, ex_dest=0, data=0), even if mem_stall=1.
  2. mem_stall=1: hold all EX registers unchanged.
  3. lu_hazard=1: load bubble. The next cycle ex_op=OP_NOP, so the hazard clears and decode's held instruction is captured with fresh forwarding. Stall length is exactly 1 cycle per load-use.
  4. id_valid=1: capture id_op, id_dest, opA, opB, store_data; ex_valid=1.
  5. else: load bubble.
- Latency: 1 cycle from decode to EX outputs.
- Register index 0 is treated like any other index. No special-casing.
- Back-to-back loads each dependent on the previous: a bubble is inserted after every load.

Optional Feature:
- Macro: EX_BUBBLE_CNT_EN.
- When defined: adds output bubble_cnt (16 bits), reset to 0. It increments on every edge that loads a bubble due to lu_hazard (rule 3 only), and saturates at 16'hFFFF.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: drive reset_n=0 mid-operation with ex_valid=1 -> all outputs zero/NOP asynchronously, stall_out=0.
- Forward select: id_op=4'b0001, fwd_sel1=01, alu_result=32'h1234, fwd_sel2=11, wb_result=32'hBEEF, id_use_imm=0 -> next cycle ex_opA=32'h1234, ex_opB=32'hBEEF, ex_valid=1.
- Load-use: EX holds LW dest=5; decode reads reg1=5 -> stall_out=1 that cycle, next cycle ex_op=OP_NOP/ex_valid=0. The following edge captures the instruction with fwd_sel1=10, mem_result=32'hA5A5 -> ex_opA=32'hA5A5.
- Flush beats stall: lu_hazard=1, mem_stall=1, flush=1 together -> stall_out=0, next cycle ex_valid=0, ex_op=OP_NOP.
- Mem freeze: ex holds op=4'b0001/opA=7; mem_stall=1 for 3 cycles with changing inputs -> EX outputs unchanged, stall_out=1 throughout.
- Store data: id_op=OP_SW, id_use_imm=1, id_imm=8, fwd_sel2=10, mem_result=32'h55 -> ex_opB=8, ex_store_data=32'h55. With EX_BUBBLE_CNT_EN, two load-use events -> bubble_cnt=2.
